hf_tans_frame_ctrl: RTL and testbench

Frame sequencer for the HF tANS recoder datapath. Buffers one frame of 2-bit Huffman symbols and replays it back-to-back into the recoder, asserting the init flag on the first symbol. Samples the recoder's BTR/o_stream outputs at the correct pipeline offsets and packs the emitted bits into fixed-width words. Captures the final tANS state at end of frame. Sits between the upstream symbol source and the recoder, and drives all recoder inputs.

---
 rtl/hf_tans_frame_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_hf_tans_frame_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hf_tans_frame_ctrl.sv
// Frame sequencer for the HF tANS recoder: buffers one frame of 2-bit symbols, replays it
// into the recoder, packs emitted bits into OUT_W-bit words. HF_TANS_CTRL_STATS_EN adds counters.
module hf_tans_frame_ctrl #(
    parameter int FRAME_MAX = 16,
    parameter int OUT_W     = 8,
    parameter int LAT       = 4
) (
    input  logic                       PHI,
    input  logic                       RST,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [1:0]                 s_symbol,
    input  logic                       s_last,
    output logic                       rc_init,
    output logic [1:0]                 rc_symbol,
    input  logic [1:0]                 rc_btr,
    input  logic [2:0]                 rc_bits,
    input  logic [3:0]                 rc_state,
    output logic                       o_valid,
    output logic [OUT_W-1:0]           o_word,
    output logic [$clog2(OUT_W+1)-1:0] o_nbits,
    output logic                       done,
    output logic [3:0]                 final_state,
    output logic                       err_ovf
`ifdef HF_TANS_CTRL_STATS_EN
    ,
    output logic [15:0]                stat_frames,
    output logic [23:0]                stat_bits
`endif
);

    localparam int NB_W     = $clog2(OUT_W + 1);
    localparam int CNT_W    = $clog2(FRAME_MAX + 1);
    localparam int IDX_W    = $clog2(FRAME_MAX);
    localparam int ACC_W    = OUT_W + 3;
    localparam int PK_W     = $clog2(OUT_W + 3);
    localparam int TAG_SAMP = 0;
    localparam int TAG_FIN  = 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W-1:0]   n_last_q;
    logic               s_ready_q;
    logic               rc_init_q;
    logic [1:0]         rc_symbol_q;
    logic [1:0]         tag_pres_q;
    logic [1:0]         tag_sr_q [LAT];
    logic [1:0]         tag_act;
    logic [ACC_W-1:0]   acc_q;
    logic [PK_W-1:0]    pk_cnt_q;
    logic               o_valid_q;
    logic [OUT_W-1:0]   o_word_q;
    logic [NB_W-1:0]    o_nbits_q;
    logic               done_q;
    logic [3:0]         final_state_q;
    logic               err_ovf_q;

    logic [1:0]         sym_mem [FRAME_MAX];

    logic [3:0]         bit_mask_d;
    logic [2:0]         app_bits_d;
    logic [ACC_W-1:0]   acc_sum_d;
    logic [PK_W-1:0]    cnt_sum_d;

    // Symbol buffer: plain array with registered read in the RUN branch below
    always_ff @(posedge PHI) begin
        if (state_q == ST_LOAD && s_valid && s_ready_q) begin
            sym_mem[cnt_q[IDX_W-1:0]] <= s_symbol;
        end
    end

    // Tags travel alongside the recoder pipeline: bit0 = sample, bit1 = final
    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LAT; i++) begin
                tag_sr_q[i] <= 2'b00;
            end
        end else begin
            tag_sr_q[0] <= tag_pres_q;
            for (int i = 1; i < LAT; i++) begin
                tag_sr_q[i] <= tag_sr_q[i-1];
            end
        end
    end

    assign tag_act = tag_sr_q[LAT-1];

    always_comb begin
        bit_mask_d = (4'd1 << rc_btr) - 4'd1;
        app_bits_d = rc_bits & bit_mask_d[2:0];
        acc_sum_d  = acc_q | (ACC_W'(app_bits_d) << pk_cnt_q);
        cnt_sum_d  = pk_cnt_q + PK_W'(rc_btr);
    end

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            state_q       <= ST_LOAD;
            cnt_q         <= '0;
            k_q           <= '0;
            n_last_q      <= '0;
            s_ready_q     <= 1'b1;
            rc_init_q     <= 1'b0;
            rc_symbol_q   <= 2'b01;
            tag_pres_q    <= 2'b00;
            acc_q         <= '0;
            pk_cnt_q      <= '0;
            o_valid_q     <= 1'b0;
            o_word_q      <= '0;
            o_nbits_q     <= '0;
            done_q        <= 1'b0;
            final_state_q <= 4'h0;
            err_ovf_q     <= 1'b0;
        end else begin
            o_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            rc_init_q   <= 1'b0;
            rc_symbol_q <= 2'b01;
            tag_pres_q  <= 2'b00;

            // rc_btr <= 3 < OUT_W, so one append can complete at most one word
            if (tag_act[TAG_SAMP]) begin
                if (cnt_sum_d >= PK_W'(OUT_W)) begin
                    o_valid_q <= 1'b1;
                    o_word_q  <= acc_sum_d[OUT_W-1:0];
                    o_nbits_q <= NB_W'(OUT_W);
                    acc_q     <= acc_sum_d >> OUT_W;
                    pk_cnt_q  <= cnt_sum_d - PK_W'(OUT_W);
                end else begin
                    acc_q    <= acc_sum_d;
                    pk_cnt_q <= cnt_sum_d;
                end
            end

            case (state_q)
                ST_LOAD: begin
                    if (s_valid && s_ready_q) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (s_last || cnt_q == CNT_W'(FRAME_MAX - 1)) begin
                            n_last_q  <= cnt_q[IDX_W-1:0];
                            k_q       <= '0;
                            s_ready_q <= 1'b0;
                            state_q   <= ST_RUN;
                            if (!s_last) begin
                                err_ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    rc_symbol_q <= sym_mem[k_q];
                    rc_init_q   <= (k_q == '0);
                    if (k_q == n_last_q) begin
                        tag_pres_q <= 2'b10;
                        state_q    <= ST_DRAIN;
                    end else begin
                        tag_pres_q <= 2'b01;
                        k_q        <= k_q + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Final symbol is never sampled, so the accumulator is settled here
                    if (tag_act[TAG_FIN]) begin
                        final_state_q <= rc_state;
                        done_q        <= 1'b1;
                        state_q       <= ST_FLUSH;
                        if (pk_cnt_q != '0) begin
                            o_valid_q <= 1'b1;
                            o_word_q  <= acc_q[OUT_W-1:0];
                            o_nbits_q <= NB_W'(pk_cnt_q);
                        end
                        acc_q    <= '0;
                        pk_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    cnt_q     <= '0;
                    s_ready_q <= 1'b1;
                    state_q   <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign rc_init     = rc_init_q;
    assign rc_symbol   = rc_symbol_q;
    assign o_valid     = o_valid_q;
    assign o_word      = o_word_q;
    assign o_nbits     = o_nbits_q;
    assign done        = done_q;
    assign final_state = final_state_q;
    assign err_ovf     = err_ovf_q;

`ifdef HF_TANS_CTRL_STATS_EN
    logic [15:0] stat_frames_q;
    logic [23:0] stat_bits_q;
    logic [24:0] bits_sum_d;

    assign bits_sum_d = {1'b0, stat_bits_q} + 25'(rc_btr);

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            stat_frames_q <= '0;
            stat_bits_q   <= '0;
        end else begin
            if (state_q == ST_DRAIN && tag_act[TAG_FIN] && stat_frames_q != 16'hFFFF) begin
                stat_frames_q <= stat_frames_q + 16'd1;
            end
            if (tag_act[TAG_SAMP]) begin
                stat_bits_q <= bits_sum_d[24] ? 24'hFFFFFF : bits_sum_d[23:0];
            end
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_bits   = stat_bits_q;
`endif

endmodule

// File: tb/tb_hf_tans_frame_ctrl.sv
// Randomized bench for hf_tans_frame_ctrl with a behavioural recoder stand-in and a
// frame-level reference model (bit stream -> words, final state, latencies).
module tb_hf_tans_frame_ctrl;

    localparam int FRAME_MAX = 16;
    localparam int OUT_W     = 8;
    localparam int LAT       = 4;
    localparam int NB_W      = $clog2(OUT_W + 1);
    localparam int LOG_DEPTH = 8192;

    logic             PHI = 1'b0;
    logic             RST;
    logic             s_valid;
    logic             s_ready;
    logic [1:0]       s_symbol;
    logic             s_last;
    logic             rc_init;
    logic [1:0]       rc_symbol;
    logic [1:0]       rc_btr;
    logic [2:0]       rc_bits;
    logic [3:0]       rc_state;
    logic             o_valid;
    logic [OUT_W-1:0] o_word;
    logic [NB_W-1:0]  o_nbits;
    logic             done;
    logic [3:0]       final_state;
    logic             err_ovf;
`ifdef HF_TANS_CTRL_STATS_EN
    logic [15:0]      stat_frames;
    logic [23:0]      stat_bits;
`endif

    hf_tans_frame_ctrl #(.FRAME_MAX(FRAME_MAX), .OUT_W(OUT_W), .LAT(LAT)) dut (
        .PHI(PHI), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_symbol(s_symbol), .s_last(s_last),
        .rc_init(rc_init), .rc_symbol(rc_symbol),
        .rc_btr(rc_btr), .rc_bits(rc_bits), .rc_state(rc_state),
        .o_valid(o_valid), .o_word(o_word), .o_nbits(o_nbits),
        .done(done), .final_state(final_state), .err_ovf(err_ovf)
`ifdef HF_TANS_CTRL_STATS_EN
        , .stat_frames(stat_frames), .stat_bits(stat_bits)
`endif
    );

    always #5 PHI = ~PHI;

    int cyc = 0;
    always @(posedge PHI) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Recoder stand-in: response depends on symbol and position since rc_init
    int salt       = 1;
    bit fixed_mode = 1'b0;

    function automatic logic [8:0] resp(input logic [1:0] sym, input int p, input int s, input bit fx);
        logic [31:0] h;
        logic [3:0]  st;
        logic [1:0]  b;
        logic [2:0]  v;
        h = (32'(p) * 32'h9E3779B1) ^ (32'(s) * 32'h000085EB) ^ (32'(sym) * 32'd97);
        h = h ^ (h >> 15);
        b = h[1:0];
        v = h[4:2];
        if (fx) begin
            b = 2'd3;
            v = 3'b101;
        end
        case (sym)
            2'b00:   st = 4'h8;
            2'b01:   st = 4'h0;
            2'b10:   st = 4'hD;
            default: st = 4'hF;
        endcase
        if (p != 0) st = h[11:8];
        return {st, v, b};
    endfunction

    logic [8:0] pipe [LAT];
    int         pos = 0;

    initial for (int i = 0; i < LAT; i++) pipe[i] = 9'd0;

    always @(posedge PHI) begin
        int p;
        p = rc_init ? 0 : pos;
        pos <= p + 1;
        pipe[0] <= resp(rc_symbol, p, salt, fixed_mode);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign rc_btr   = pipe[LAT-1][1:0];
    assign rc_bits  = pipe[LAT-1][4:2];
    assign rc_state = pipe[LAT-1][8:5];

    // Monitor logs, sampled on the falling edge
    logic [1:0]       sym_at [LOG_DEPTH];
    int               init_cyc[$];
    int               done_cyc[$];
    logic [3:0]       done_fs[$];
    logic [OUT_W-1:0] w_word[$];
    int               w_nb[$];
    int               w_frame[$];

    always @(negedge PHI) begin
        if (cyc < LOG_DEPTH) sym_at[cyc] = rc_symbol;
        if (rc_init) init_cyc.push_back(cyc);
        if (o_valid) begin
            w_word.push_back(o_word);
            w_nb.push_back(int'(o_nbits));
            w_frame.push_back(done_cyc.size());
        end
        if (done) begin
            done_cyc.push_back(cyc);
            done_fs.push_back(final_state);
        end
    end

    // Reference frames as split by the frame rules (s_last or FRAME_MAX)
    logic [1:0] all_syms[$];
    int         fr_start[$];
    int         fr_n[$];
    int         fr_salt[$];
    bit         fr_fixed[$];
    int         exp_bits_total = 0;

    task automatic clear_logs();
        init_cyc.delete(); done_cyc.delete(); done_fs.delete();
        w_word.delete(); w_nb.delete(); w_frame.delete();
        all_syms.delete(); fr_start.delete(); fr_n.delete(); fr_salt.delete(); fr_fixed.delete();
    endtask

    task automatic send_stream(input int n, input bit last_at_end, input bit toggle, input int forced);
        int         i = 0;
        int         guard = 0;
        int         cur = 0;
        logic [1:0] sym;
        bit         lst;
        while (i < n && guard < 2000) begin
            @(negedge PHI);
            guard++;
            if (toggle && (guard % 2 == 0)) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                continue;
            end
            if (s_ready) begin
                sym = (forced < 0) ? 2'($urandom_range(0, 3)) : 2'(forced);
                lst = last_at_end && (i == n - 1);
                s_valid  = 1'b1;
                s_symbol = sym;
                s_last   = lst;
                all_syms.push_back(sym);
                cur++;
                i++;
                if (lst || cur == FRAME_MAX) begin
                    fr_start.push_back(all_syms.size() - cur);
                    fr_n.push_back(cur);
                    fr_salt.push_back(salt);
                    fr_fixed.push_back(fixed_mode);
                    cur = 0;
                end
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
        end
        @(negedge PHI);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i < n) check("send_timeout", i, n);
    endtask

    task automatic wait_frames(input int want);
        int g = 0;
        while (done_cyc.size() < want && g < 600) begin
            @(negedge PHI);
            g++;
        end
        if (done_cyc.size() < want) check("done_timeout", done_cyc.size(), want);
        repeat (3) @(negedge PHI);
    endtask

    task automatic check_frame(input int f);
        int               t0, n, st, oi;
        bit               bq[$];
        logic [8:0]       r;
        logic [OUT_W-1:0] ew[$];
        int               enb[$];
        logic [OUT_W-1:0] w;
        logic [3:0]       efs;
        n  = fr_n[f];
        st = fr_start[f];
        check("frame_seen", (f < init_cyc.size() && f < done_cyc.size()), 1);
        if (!(f < init_cyc.size() && f < done_cyc.size())) return;
        t0 = init_cyc[f];
        for (int k = 0; k < n; k++) begin
            if (t0 + k < LOG_DEPTH) check("rc_symbol", sym_at[t0+k], all_syms[st+k]);
        end
        if (t0 + n < LOG_DEPTH) check("rc_symbol_idle", sym_at[t0+n], 2'b01);
        for (int k = 0; k < n - 1; k++) begin
            r = resp(all_syms[st+k], k, fr_salt[f], fr_fixed[f]);
            exp_bits_total += int'(r[1:0]);
            for (int b = 0; b < int'(r[1:0]); b++) bq.push_back(r[2+b]);
        end
        while (bq.size() >= OUT_W) begin
            w = '0;
            for (int b = 0; b < OUT_W; b++) w[b] = bq.pop_front();
            ew.push_back(w);
            enb.push_back(OUT_W);
        end
        if (bq.size() > 0) begin
            enb.push_back(bq.size());
            w = '0;
            for (int b = 0; bq.size() > 0; b++) w[b] = bq.pop_front();
            ew.push_back(w);
        end
        oi = 0;
        for (int i = 0; i < w_word.size(); i++) begin
            if (w_frame[i] == f) begin
                if (oi < ew.size()) begin
                    check("o_word", w_word[i], ew[oi]);
                    check("o_nbits", w_nb[i], enb[oi]);
                end
                oi++;
            end
        end
        check("word_count", oi, ew.size());
        r   = resp(all_syms[st+n-1], n - 1, fr_salt[f], fr_fixed[f]);
        efs = r[8:5];
        check("final_state", done_fs[f], efs);
        check("done_latency", done_cyc[f] - t0, n + LAT);
        $display("[TB] frame %0d N=%0d t0=%0d words=%0d final_state=%h", f, n, t0, oi, done_fs[f]);
    endtask

    initial begin
        int t0;
        int g;
        int nw;
        int idx[$];
        RST = 1'b1; s_valid = 1'b0; s_symbol = 2'b00; s_last = 1'b0;
        repeat (3) @(negedge PHI);
        check("rst_s_ready", s_ready, 1);
        check("rst_rc_symbol", rc_symbol, 2'b01);
        check("rst_rc_init", rc_init, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_word", o_word, 0);
        check("rst_o_nbits", o_nbits, 0);
        check("rst_done", done, 0);
        check("rst_final_state", final_state, 0);
        check("rst_err_ovf", err_ovf, 0);
        RST = 1'b0;
        @(negedge PHI);

        // Reset while the frame is draining: nothing may come out
        fixed_mode = 1'b1;
        send_stream(3, 1'b1, 1'b0, -1);
        g = 0;
        while (init_cyc.size() == 0 && g < 100) begin @(negedge PHI); g++; end
        check("abort_init_seen", init_cyc.size(), 1);
        t0 = (init_cyc.size() > 0) ? init_cyc[0] : cyc;
        while (cyc < t0 + 3) @(negedge PHI);
        RST = 1'b1;
        @(negedge PHI);
        check("abort_s_ready", s_ready, 1);
        RST = 1'b0;
        repeat (12) @(negedge PHI);
        check("abort_done", done_cyc.size(), 0);
        check("abort_words", w_word.size(), 0);
        check("abort_s_ready_after", s_ready, 1);
        clear_logs();

        send_stream(3, 1'b1, 1'b0, -1);
        wait_frames(1);

        send_stream(5, 1'b1, 1'b0, -1);
        wait_frames(2);
        idx = w_frame.find_index() with (item == 1);
        check("fixed_word_count", idx.size(), 2);
        if (idx.size() == 2) begin
            check("fixed_w0", w_word[idx[0]], 8'h6D);
            check("fixed_nb0", w_nb[idx[0]], 8);
            check("fixed_w1", w_word[idx[1]], 8'h0B);
            check("fixed_nb1", w_nb[idx[1]], 4);
        end
        fixed_mode = 1'b0;

        send_stream(1, 1'b1, 1'b0, 2);
        wait_frames(3);
        nw = 0;
        foreach (w_frame[i]) if (w_frame[i] == 2) nw++;
        check("n1_no_words", nw, 0);
        if (done_fs.size() > 2) check("n1_final_state", done_fs[2], 4'hD);
        check("err_ovf_clear", err_ovf, 0);

        salt = $urandom;
        send_stream(20, 1'b1, 1'b0, -1);
        wait_frames(5);
        check("err_ovf_set", err_ovf, 1);
        check("ovf_frame_len", fr_n[3], FRAME_MAX);

        salt = $urandom;
        send_stream(10, 1'b1, 1'b1, -1);
        wait_frames(6);

        for (int i = 0; i < 8; i++) begin
            salt = $urandom;
            send_stream($urandom_range(1, FRAME_MAX), 1'b1, 1'($urandom_range(0, 1)), -1);
            wait_frames(fr_n.size());
        end

        repeat (10) @(negedge PHI);
        for (int f = 0; f < fr_n.size(); f++) check_frame(f);
        check("init_count", init_cyc.size(), fr_n.size());
        check("done_count", done_cyc.size(), fr_n.size());
        check("err_ovf_sticky", err_ovf, 1);
`ifdef HF_TANS_CTRL_STATS_EN
        check("stat_frames", stat_frames, fr_n.size());
        check("stat_bits", stat_bits, exp_bits_total);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
